// File: rtl/vga_pixel_out.sv
// vga_pixel_out: region decode, palette lookup, sync alignment and frame-end palette commit for the VGA output stage
module vga_pixel_out #(
    parameter int          SCREEN_WIDTH = 10,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [11:0] BORDER_RGB   = 12'hFFF,
    parameter logic [11:0] BG_RGB       = 12'h000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] info,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  pal_we,
    input  logic [3:0]            pal_addr,
    input  logic [11:0]           pal_wdata,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt,
    output logic                  pal_pending
);
    typedef enum logic {CLEAN, DIRTY} state_t;
    localparam logic [SCREEN_WIDTH-1:0] X_W0 = SCREEN_WIDTH'(80);
    localparam logic [SCREEN_WIDTH-1:0] X_W1 = SCREEN_WIDTH'(560);
    localparam logic [SCREEN_WIDTH-1:0] Y_W0 = SCREEN_WIDTH'(100);
    localparam logic [SCREEN_WIDTH-1:0] Y_W1 = SCREEN_WIDTH'(380);
    localparam logic [SCREEN_WIDTH-1:0] X_B0 = SCREEN_WIDTH'(77);
    localparam logic [SCREEN_WIDTH-1:0] X_B1 = SCREEN_WIDTH'(563);
    localparam logic [SCREEN_WIDTH-1:0] Y_B0 = SCREEN_WIDTH'(97);
    localparam logic [SCREEN_WIDTH-1:0] Y_B1 = SCREEN_WIDTH'(383);
    localparam logic [SCREEN_WIDTH-1:0] X_MAX = SCREEN_WIDTH'(640);
    localparam logic [SCREEN_WIDTH-1:0] Y_MAX = SCREEN_WIDTH'(480);

    state_t                  r_state, w_next;
    logic [11:0]             r_shadow [16];
    logic [11:0]             r_act [16];
    logic [11:0]             r_rgb, w_rgb;
    logic                    r_hs1, r_vs1, r_hs, r_vs;
    logic                    r_fe_prev, r_done;
    logic [15:0]             r_frame_cnt;
    logic [SCREEN_WIDTH-1:0] w_x, w_y;
    logic [3:0]              w_idx;
    logic                    w_edge, w_commit, w_blank, w_win, w_box;
    logic                    w_unused;

    assign w_x      = info[18 +: SCREEN_WIDTH];
    assign w_y      = info[8 +: SCREEN_WIDTH];
    assign w_idx    = info[3:0];
    assign w_unused = ^{info[DATA_WIDTH-2:18+SCREEN_WIDTH], info[7:4]};
    assign w_edge   = info[DATA_WIDTH-1] & ~r_fe_prev;
    assign w_commit = w_edge & (r_state == DIRTY);
    assign w_blank  = (w_x >= X_MAX) | (w_y >= Y_MAX);
    assign w_win    = (w_x >= X_W0) & (w_x < X_W1) & (w_y >= Y_W0) & (w_y < Y_W1);
    assign w_box    = (w_x >= X_B0) & (w_x < X_B1) & (w_y >= Y_B0) & (w_y < Y_B1);

    // Pixel colour by region; window pixels read the active palette as it stands before any commit on this edge
    always_comb begin
        w_rgb = w_blank ? 12'h000 : w_win ? r_act[w_idx] : w_box ? BORDER_RGB : BG_RGB;
    end

    // Commit FSM next state: a write always leaves the shadow dirty, even on the commit edge
    always_comb begin
        w_next = r_state;
        w_next = pal_we ? DIRTY : (w_edge ? CLEAN : r_state);
    end

    // Commit FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= CLEAN;
        else        r_state <= w_next;
    end

    // Palettes: commit copies the pre-write shadow, a coinciding write still lands in shadow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_shadow[i] <= {3{4'(i)}};
                r_act[i]    <= {3{4'(i)}};
            end
        end else begin
            if (w_commit) r_act <= r_shadow;
            if (pal_we)   r_shadow[pal_addr] <= pal_wdata;
        end
    end

    // Output pipeline: colour, two-stage sync delay, frame-end edge detection and counting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rgb       <= 12'h000;
            r_hs1       <= 1'b1;
            r_vs1       <= 1'b1;
            r_hs        <= 1'b1;
            r_vs        <= 1'b1;
            r_fe_prev   <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= 16'h0000;
        end else begin
            r_rgb       <= w_rgb;
            r_hs1       <= hsync_in;
            r_vs1       <= vsync_in;
            r_hs        <= r_hs1;
            r_vs        <= r_vs1;
            r_fe_prev   <= info[DATA_WIDTH-1];
            r_done      <= w_edge;
            r_frame_cnt <= r_frame_cnt + {15'd0, w_edge};
        end
    end

    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];
    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign frame_done  = r_done;
    assign frame_cnt   = r_frame_cnt;
    assign pal_pending = (r_state == DIRTY);
endmodule

// File: tb/tb_vga_pixel_out.sv
// tb_vga_pixel_out: directed bench for vga_pixel_out with a per-cycle behavioural model and literal spot checks
module tb_vga_pixel_out;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] info;
    logic        hsync_in, vsync_in, pal_we;
    logic [3:0]  pal_addr;
    logic [11:0] pal_wdata;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, frame_done, pal_pending;
    logic [15:0] frame_cnt;

    logic [11:0] m_shadow [16];
    logic [11:0] m_act [16];
    logic [11:0] m_rgb;
    logic        m_hs1, m_vs1, m_hs, m_vs, m_done, m_pend, m_fe, m_edge;
    logic [15:0] m_cnt;
    bit          chk_en = 0;
    int          checks = 0;
    int          errors = 0;

    vga_pixel_out dut (
        .clk(clk), .rst_n(rst_n), .info(info), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync(hsync), .vsync(vsync),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .pal_pending(pal_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] colour(input int x, input int y, input int idx);
        if (x >= 640 || y >= 480) return 12'h000;
        if (x >= 80 && x < 560 && y >= 100 && y < 380) return m_act[idx];
        if (x >= 77 && x < 563 && y >= 97 && y < 383) return 12'hFFF;
        return 12'h000;
    endfunction

    // Behavioural model: what the outputs must show after each edge
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                m_shadow[i] = {3{4'(i)}};
                m_act[i]    = {3{4'(i)}};
            end
            m_rgb = 0; m_hs1 = 1; m_vs1 = 1; m_hs = 1; m_vs = 1;
            m_done = 0; m_pend = 0; m_fe = 0; m_cnt = 0;
        end else begin
            m_edge = info[31] && !m_fe;
            m_rgb  = colour(int'(info[27:18]), int'(info[17:8]), int'(info[3:0]));
            if (m_edge && m_pend) m_act = m_shadow;
            m_pend = pal_we ? 1'b1 : (m_edge ? 1'b0 : m_pend);
            if (pal_we) m_shadow[pal_addr] = pal_wdata;
            m_done = m_edge;
            if (m_edge) m_cnt = m_cnt + 16'd1;
            m_fe = info[31];
            m_hs = m_hs1; m_hs1 = hsync_in;
            m_vs = m_vs1; m_vs1 = vsync_in;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rgb_model", {vga_r, vga_g, vga_b}, m_rgb);
            chk("hsync_model", hsync, m_hs);
            chk("vsync_model", vsync, m_vs);
            chk("frame_done_model", frame_done, m_done);
            chk("frame_cnt_model", frame_cnt, m_cnt);
            chk("pal_pending_model", pal_pending, m_pend);
        end
    end

    task automatic px(input int x, input int y, input int idx, input bit fe);
        info = {fe, 3'b000, 10'(x), 10'(y), 4'b0000, 4'(idx)};
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    int          rx [6] = '{80, 79, 76, 562, 640, 560};
    int          ry [6] = '{100, 100, 100, 382, 10, 379};
    logic [11:0] rexp [6] = '{12'h333, 12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF};

    initial begin
        rst_n = 0; info = 0; hsync_in = 1; vsync_in = 1; pal_we = 0; pal_addr = 0; pal_wdata = 0;
        for (int i = 0; i < 3; i++) begin
            info = $urandom; hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            pal_we = 1'($urandom); pal_addr = 4'($urandom); pal_wdata = 12'($urandom);
            step();
            chk_en = 1;
        end
        chk("reset_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        chk("reset_hsync", hsync, 1'b1);
        chk("reset_vsync", vsync, 1'b1);
        chk("reset_cnt", frame_cnt, 16'h0);
        chk("reset_pending", pal_pending, 1'b0);
        rst_n = 1; hsync_in = 1; vsync_in = 1; pal_we = 0;
        px(100, 200, 5, 0); step();
        chk("grey_idx5", {vga_r, vga_g, vga_b}, 12'h555);
        for (int i = 0; i < 6; i++) begin
            px(rx[i], ry[i], 3, 0); step();
            chk("region", {vga_r, vga_g, vga_b}, rexp[i]);
        end
        hsync_in = 0; step(); hsync_in = 1;
        chk("hsync_n1", hsync, 1'b1);
        step();
        chk("hsync_n2", hsync, 1'b0);
        chk("vsync_hold", vsync, 1'b1);
        step();
        chk("hsync_n3", hsync, 1'b1);
        px(100, 200, 3, 0); pal_we = 1; pal_addr = 3; pal_wdata = 12'hF00; step(); pal_we = 0;
        chk("shadow_hidden", {vga_r, vga_g, vga_b}, 12'h333);
        chk("pending_set", pal_pending, 1'b1);
        step();
        chk("shadow_hidden2", {vga_r, vga_g, vga_b}, 12'h333);
        px(640, 0, 0, 1); step();
        chk("commit_done", frame_done, 1'b1);
        chk("commit_pending", pal_pending, 1'b0);
        chk("commit_cnt", frame_cnt, 16'd1);
        px(100, 200, 3, 0); step();
        chk("commit_rgb", {vga_r, vga_g, vga_b}, 12'hF00);
        pal_we = 1; pal_addr = 2; pal_wdata = 12'h0F0; step(); pal_we = 0;
        px(640, 0, 0, 1); pal_we = 1; pal_addr = 7; pal_wdata = 12'h00F; step(); pal_we = 0;
        chk("coll_done", frame_done, 1'b1);
        chk("coll_pending", pal_pending, 1'b1);
        px(100, 200, 2, 0); step();
        chk("coll_idx2", {vga_r, vga_g, vga_b}, 12'h0F0);
        px(100, 200, 7, 0); step();
        chk("coll_idx7_old", {vga_r, vga_g, vga_b}, 12'h777);
        px(640, 0, 0, 1); step();
        chk("coll2_pending", pal_pending, 1'b0);
        chk("coll2_cnt", frame_cnt, 16'd3);
        px(100, 200, 7, 0); step();
        chk("coll_idx7_new", {vga_r, vga_g, vga_b}, 12'h00F);
        px(640, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_done", frame_done, i == 0);
        end
        px(100, 200, 1, 0); step();
        chk("hold_cnt", frame_cnt, 16'd4);
        #2;
        force dut.r_frame_cnt = 16'hFFFF;
        m_cnt = 16'hFFFF;
        step();
        #2;
        release dut.r_frame_cnt;
        step();
        chk("preload_cnt", frame_cnt, 16'hFFFF);
        px(640, 0, 0, 1); step();
        chk("wrap_cnt", frame_cnt, 16'h0000);
        chk("wrap_done", frame_done, 1'b1);
        px(100, 200, 1, 0); step();
        chk("wrap_rgb", {vga_r, vga_g, vga_b}, 12'h111);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_pixel_out.md
# vga_pixel_out

Final pixel stage of the VGA display path. It consumes the registered 32-bit pixel-info word from the screen-RAM fetch stage and produces 12-bit RGB (4:4:4) aligned with delayed hsync/vsync. It drives three regions: the 480x280 framebuffer window (through a 16-entry programmable palette), a 3-pixel border around that window, and a black background. Palette updates from the CPU are double-buffered and committed at frame end so the display never tears mid-frame.

## Interface
Parameters:
- SCREEN_WIDTH, 10, width of the x/y fields inside the info word
- DATA_WIDTH, 32, info word width
- BORDER_RGB, 12'hFFF, border colour
- BG_RGB, 12'h000, colour outside the window and border

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- info  in  32  pixel-info word:
  - [31] frame-end flag
  - [27:18] x, clamped to 640
  - [17:8] y, clamped to 480
  - [3:0] palette index
- hsync_in  in  1  horizontal sync, active-low, same cycle as the x/y that produced info
- vsync_in  in  1  vertical sync, active-low, same cycle as the x/y that produced info
- pal_we  in  1  shadow-palette write strobe
- pal_addr  in  4  shadow-palette entry
- pal_wdata  in  12  {R,G,B} entry value
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- hsync  out  1  delayed hsync_in
- vsync  out  1  delayed vsync_in
- frame_done  out  1  one-cycle pulse per frame
- frame_cnt  out  16  frames completed since reset
- pal_pending  out  1  shadow palette differs from active palette, commit pending

## Operation
- Region decode uses x = info[27:18] and y = info[17:8]:
  - WINDOW: 80 ≤ x < 560 and 100 ≤ y < 380
  - BORDER: 77 ≤ x < 563 and 97 ≤ y < 383, excluding WINDOW
  - BLANK: x ≥ 640 or y ≥ 480
  - BG: everything else
- Colour per region:
  - WINDOW → active_pal[info[3:0]]
  - BORDER → BORDER_RGB
  - BG → BG_RGB
  - BLANK → 12'h000
- Palettes: two 16x12 register files, shadow and active.
  - pal_we writes shadow[pal_addr] and sets pal_pending.
- Frame end: fe_prev is info[31] registered. A frame edge is info[31]=1 with fe_prev=0; an info[31] held high over several cycles counts once.
- On a frame edge:
  - frame_done pulses for one cycle.
  - frame_cnt increments, wrapping 16'hFFFF→0.
  - If pal_pending, active ← shadow entirely and pal_pending clears.
- pal_we coinciding with the commit edge:
  - The commit copies shadow as it stood before the write.
  - The write lands in shadow.
  - pal_pending remains 1.
- Commit state machine:
  - CLEAN: pal_pending=0. pal_we → DIRTY.
  - DIRTY: pal_pending=1. Frame edge without pal_we → CLEAN. Frame edge with pal_we → DIRTY.
- Reset (rst_n=0 at a clk edge), including mid-frame:
  - shadow[i] = active[i] = {i,i,i} (grey ramp)
  - vga_r/g/b = 0, hsync = vsync = 1, sync delay registers = 1
  - frame_done = 0, frame_cnt = 0, pal_pending = 0, fe_prev = 0

## Timing
- info → RGB: 1 cycle. RGB is registered from the info value sampled at the edge.
- hsync_in/vsync_in → hsync/vsync: 2 cycles, matching the 1-cycle fetch stage plus this stage.
- frame_done: asserted in the cycle after the edge on which info[31] rises.
- frame_cnt and the active palette change on that same edge.
- The first pixel that uses new palette values is the info sampled on the following edge.
- A shadow write is never visible on the output before a commit.
- All outputs are registered; no combinational input→output path.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random inputs → RGB=0, hsync=vsync=1, frame_cnt=0, pal_pending=0. Then index 5 at x=100, y=200 → RGB=12'h555.
- Region decode:
  - x=80, y=100, idx=3 → 12'h333
  - x=79, y=100 → 12'hFFF
  - x=76, y=100 → 12'h000
  - x=562, y=382 → 12'hFFF
  - x=640, y=10 → 12'h000
- Sync alignment: toggle hsync_in for one cycle at cycle N → hsync low exactly at cycle N+2. Check in the same run that vsync holds.
- Palette commit:
  - write pal[3]=12'hF00 mid-frame → WINDOW idx 3 still shows 12'h333, pal_pending=1
  - raise info[31] → next cycle frame_done=1, pal_pending=0
  - following pixel idx 3 → 12'hF00
- Commit collision: pal_we to entry 7 on the same edge as the frame-end rise → commit does not include entry 7, pal_pending stays 1. Entry 7 appears only after the next frame end.
- Frame counter: hold info[31]=1 for 4 cycles → single frame_done pulse. Preload 16'hFFFF via 65535 frames (or force) → next frame end wraps frame_cnt to 0.
